// File: rtl/timestable_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : timestable_rd_arbiter
// Description : Round-robin arbiter for two operand requesters that share one
//               64-entry times-table memory behind an AXI4-lite read port.
//               Each granted request issues one AR/R handshake. The 6-bit
//               product then comes back with a one-cycle done pulse and an
//               error flag.
// Ports       : clk, rst              - clock, synchronous active-high reset
//               req0/req1             - level requests, held until done
//               a0,b0 / a1,b1         - 3-bit operands, sampled at grant
//               done0/done1           - one-cycle completion pulses
//               result0/result1       - product, held until the next done
//               err0/err1             - bad rresp or timeout, held like result
//               busy                  - transaction in flight (not IDLE)
//               m_axi_ar* / m_axi_r*  - AXI4-lite read address/data channels
// Revision    : 1.0 - initial release
// ============================================================================
module timestable_rd_arbiter #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [3:0]  TIMEOUT   = 4'd15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic [2:0]  a0,
    input  logic [2:0]  b0,
    input  logic        req1,
    input  logic [2:0]  a1,
    input  logic [2:0]  b1,
    output logic        done0,
    output logic [5:0]  result0,
    output logic        err0,
    output logic        done1,
    output logic [5:0]  result1,
    output logic        err1,
    output logic        busy,
    output logic [31:0] m_axi_araddr,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_last;     // port granted most recently
    logic        r_port;     // port owning the current transaction
    logic [3:0]  r_cnt;      // DATA-phase wait counter

    logic        w_any_req;
    logic        w_pick1;
    logic [2:0]  w_a;
    logic [2:0]  w_b;
    logic [31:0] w_addr;
    logic        w_unused_rdata;

    always_comb begin
        w_any_req = req0 | req1;
        // Port 1 wins when it asks alone, or on a tie when port 0 went last.
        w_pick1   = req1 & (~req0 | ~r_last);
        w_a       = w_pick1 ? a1 : a0;
        w_b       = w_pick1 ? b1 : b0;
        w_addr    = BASE_ADDR + {26'b0, w_a, w_b};
    end

    // Products fit in six bits; the upper read data is don't-care.
    assign w_unused_rdata = ^m_axi_rdata[31:6];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_last        <= 1'b1;
            r_port        <= 1'b0;
            r_cnt         <= 4'd0;
            m_axi_araddr  <= 32'd0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            done0         <= 1'b0;
            done1         <= 1'b0;
            result0       <= 6'd0;
            result1       <= 6'd0;
            err0          <= 1'b0;
            err1          <= 1'b0;
            busy          <= 1'b0;
        end else begin
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_port        <= w_pick1;
                        m_axi_araddr  <= w_addr;
                        m_axi_arvalid <= 1'b1;
                        busy          <= 1'b1;
                        r_state       <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    // arvalid stays up until accepted; no abort here.
                    if (m_axi_arvalid && m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        r_cnt         <= 4'd0;
                        r_state       <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (m_axi_rvalid && m_axi_rready) begin
                        m_axi_rready <= 1'b0;
                        if (r_port) begin
                            done1   <= 1'b1;
                            result1 <= m_axi_rdata[5:0];
                            err1    <= (m_axi_rresp != 2'b00);
                        end else begin
                            done0   <= 1'b1;
                            result0 <= m_axi_rdata[5:0];
                            err0    <= (m_axi_rresp != 2'b00);
                        end
                        r_state <= S_DONE;
                    end else if (r_cnt == (TIMEOUT - 4'd1)) begin
                        // Last permitted DATA cycle passed without rvalid.
                        // Dropping rready makes any late beat harmless.
                        m_axi_rready <= 1'b0;
                        if (r_port) begin
                            done1   <= 1'b1;
                            result1 <= 6'd0;
                            err1    <= 1'b1;
                        end else begin
                            done0   <= 1'b1;
                            result0 <= 6'd0;
                            err0    <= 1'b1;
                        end
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_DONE: begin
                    r_last  <= r_port;
                    r_cnt   <= 4'd0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_timestable_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_timestable_rd_arbiter
// Description : Self-checking bench for timestable_rd_arbiter. A cycle-level
//               transaction model predicts grant order, bus windows, done
//               timing, result and err. The same model also plays the
//               requesters and the memory slave.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timestable_rd_arbiter;

    localparam logic [31:0] BASE_ADDR = 32'h0000_0000;
    localparam logic [3:0]  TIMEOUT   = 4'd15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [2:0]  a0 = 3'd0, b0 = 3'd0, a1 = 3'd0, b1 = 3'd0;
    logic        done0, done1, err0, err1, busy;
    logic [5:0]  result0, result1;
    logic [31:0] m_axi_araddr;
    logic        m_axi_arvalid, m_axi_rready;
    logic        m_axi_arready = 1'b0;
    logic [31:0] m_axi_rdata   = 32'd0;
    logic [1:0]  m_axi_rresp   = 2'b00;
    logic        m_axi_rvalid  = 1'b0;

    timestable_rd_arbiter #(
        .BASE_ADDR (BASE_ADDR),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req0          (req0),
        .a0            (a0),
        .b0            (b0),
        .req1          (req1),
        .a1            (a1),
        .b1            (b1),
        .done0         (done0),
        .result0       (result0),
        .err0          (err0),
        .done1         (done1),
        .result1       (result1),
        .err1          (err1),
        .busy          (busy),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Model state: requesters, current transaction, held outputs.
    bit          pend [2];
    logic [2:0]  opa [2];
    logic [2:0]  opb [2];
    int          keep_left [2];
    int          keep_prob   = 0;
    int          arrive_prob = 0;
    bit          rand_slave  = 1'b0;
    bit          active      = 1'b0;
    int          port = 0, g = 0, aw = 0, rw = 0, done_at = 0;
    int          idle_edge = 0, last = 1, late = 0;
    bit          to = 1'b0, post_rst = 1'b0;
    logic [1:0]  resp = 2'b00;
    logic [31:0] rd = 32'd0, exp_addr = 32'd0;
    logic [5:0]  m_res [2];
    bit          m_err [2];
    // One-shot slave overrides for the next grant.
    bit          f_en = 1'b0, f_to = 1'b0, f_data_en = 1'b0;
    int          f_aw = 0, f_rw = 0;
    logic [1:0]  f_resp = 2'b00;
    logic [31:0] f_data = 32'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic new_ops(input int p);
        opa[p] = 3'($urandom_range(0, 7));
        opb[p] = 3'($urandom_range(0, 7));
    endtask

    task automatic set_req(input int p, input logic [2:0] a, input logic [2:0] b);
        pend[p] = 1'b1;
        opa[p]  = a;
        opb[p]  = b;
    endtask

    // One clock: check DUT against the model, then advance the model and drive.
    task automatic step();
        logic ed0, ed1, e_arv, e_rr;
        @(negedge clk);
        rst = 1'b0;
        if (active && cyc == done_at) begin
            m_res[port] = to ? 6'd0 : rd[5:0];
            m_err[port] = to || (resp != 2'b00);
        end
        ed0   = active && (cyc == done_at) && (port == 0);
        ed1   = active && (cyc == done_at) && (port == 1);
        e_arv = active && (cyc >= g) && (cyc <= g + aw);
        e_rr  = active && (cyc > g + aw) && (cyc < done_at);
        check("done0",   32'(done0),   32'(ed0));
        check("done1",   32'(done1),   32'(ed1));
        check("result0", 32'(result0), 32'(m_res[0]));
        check("result1", 32'(result1), 32'(m_res[1]));
        check("err0",    32'(err0),    32'(m_err[0]));
        check("err1",    32'(err1),    32'(m_err[1]));
        check("busy",    32'(busy),    32'(active));
        check("arvalid", 32'(m_axi_arvalid), 32'(e_arv));
        check("rready",  32'(m_axi_rready),  32'(e_rr));
        if (e_arv)
            check("araddr", m_axi_araddr, exp_addr);
        if (post_rst) begin
            check("araddr_rst", m_axi_araddr, 32'd0);
            post_rst = 1'b0;
        end

        if (active && cyc == done_at) begin
            active    = 1'b0;
            idle_edge = cyc + 2;
            if (to)
                late = 2;
            if (keep_left[port] > 0)
                keep_left[port]--;
            else if (int'($urandom_range(0, 99)) < keep_prob)
                new_ops(port);
            else
                pend[port] = 1'b0;
        end
        for (int p = 0; p < 2; p++)
            if (!pend[p] && int'($urandom_range(0, 99)) < arrive_prob) begin
                pend[p] = 1'b1;
                new_ops(p);
            end

        if (!active && (cyc + 1 >= idle_edge) && (pend[0] || pend[1])) begin
            port   = (pend[0] && pend[1]) ? ((last == 0) ? 1 : 0) : (pend[1] ? 1 : 0);
            last   = port;
            g      = cyc + 1;
            active = 1'b1;
            rd     = $urandom;
            rd[5:0] = 6'(opa[port]) * 6'(opb[port]);
            if (f_en) begin
                aw = f_aw; rw = f_rw; to = f_to; resp = f_resp;
                if (f_data_en) rd = f_data;
                f_en = 1'b0;
            end else if (rand_slave) begin
                aw   = int'($urandom_range(0, 3));
                rw   = int'($urandom_range(0, 3));
                to   = ($urandom_range(0, 7) == 0);
                resp = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            end else begin
                aw = 0; rw = 0; to = 1'b0; resp = 2'b00;
            end
            exp_addr = BASE_ADDR + {26'b0, opa[port], opb[port]};
            done_at  = to ? (g + 1 + aw + int'(TIMEOUT)) : (g + 2 + aw + rw);
        end

        // Requesters: operands of an in-flight port are scrambled, since only
        // the grant-cycle values may matter.
        req0 = pend[0];
        req1 = pend[1];
        a0 = (active && port == 0 && cyc >= g) ? 3'($urandom) : opa[0];
        b0 = (active && port == 0 && cyc >= g) ? 3'($urandom) : opb[0];
        a1 = (active && port == 1 && cyc >= g) ? 3'($urandom) : opa[1];
        b1 = (active && port == 1 && cyc >= g) ? 3'($urandom) : opb[1];
        // Memory slave, scheduled by the model.
        m_axi_arready = active && (cyc == g + aw);
        if (active && !to && cyc == done_at - 1) begin
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = rd;
            m_axi_rresp  = resp;
        end else if (late > 0) begin
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = $urandom;
            m_axi_rresp  = 2'($urandom);
            late--;
        end else begin
            m_axi_rvalid = 1'b0;
            m_axi_rdata  = $urandom;
            m_axi_rresp  = 2'($urandom);
        end
    endtask

    // Asserted for exactly one edge; the next step() releases it.
    task automatic apply_reset();
        rst       = 1'b1;
        active    = 1'b0;
        late      = 0;
        last      = 1;
        m_res[0]  = 6'd0; m_res[1] = 6'd0;
        m_err[0]  = 1'b0; m_err[1] = 1'b0;
        idle_edge = cyc + 2;
        post_rst  = 1'b1;
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
        a0 = opa[0]; b0 = opb[0]; a1 = opa[1]; b1 = opb[1];
    endtask

    task automatic run_idle(input int budget);
        int n;
        n = 0;
        while ((active || pend[0] || pend[1]) && n < budget) begin
            step();
            n++;
        end
        check("drain", 32'(active || pend[0] || pend[1]), 32'd0);
    endtask

    initial begin
        pend[0] = 1'b0; pend[1] = 1'b0;
        opa[0] = 3'd0; opb[0] = 3'd0; opa[1] = 3'd0; opb[1] = 3'd0;
        keep_left[0] = 0; keep_left[1] = 0;
        m_res[0] = 6'd0; m_res[1] = 6'd0;
        m_err[0] = 1'b0; m_err[1] = 1'b0;

        @(negedge clk);
        apply_reset();
        step();
        step();

        // Single request, zero-wait slave: 6 x 7.
        set_req(0, 3'd6, 3'd7);
        run_idle(20);
        check("single_result0", 32'(result0), 32'd42);
        check("single_err0",    32'(err0),    32'd0);

        // Tie straight after reset: port 0, then 1, then 0 again.
        apply_reset();
        set_req(0, 3'd3, 3'd5);
        set_req(1, 3'd7, 3'd7);
        keep_left[0] = 1;
        run_idle(40);
        check("tie_result0", 32'(result0), 32'd15);
        check("tie_result1", 32'(result1), 32'd49);

        // Backpressure: 3 arready waits, 2 rvalid waits.
        f_en = 1'b1; f_aw = 3; f_rw = 2; f_to = 1'b0; f_resp = 2'b00; f_data_en = 1'b0;
        set_req(0, 3'd2, 3'd4);
        run_idle(30);
        check("bp_result0", 32'(result0), 32'd8);

        // Error response, then a clean read clears err.
        f_en = 1'b1; f_aw = 0; f_rw = 0; f_to = 1'b0; f_resp = 2'b10;
        f_data_en = 1'b1; f_data = 32'h0000_001F;
        set_req(1, 3'd2, 3'd2);
        run_idle(20);
        check("slverr_err1",    32'(err1),    32'd1);
        check("slverr_result1", 32'(result1), 32'd31);
        f_data_en = 1'b0;
        set_req(1, 3'd1, 3'd5);
        run_idle(20);
        check("clean_err1",    32'(err1),    32'd0);
        check("clean_result1", 32'(result1), 32'd5);

        // Timeout, a late rvalid, then a normal read.
        f_en = 1'b1; f_aw = 0; f_rw = 0; f_to = 1'b1; f_resp = 2'b00;
        set_req(0, 3'd5, 3'd5);
        run_idle(40);
        check("to_err0",    32'(err0),    32'd1);
        check("to_result0", 32'(result0), 32'd0);
        set_req(0, 3'd4, 3'd4);
        run_idle(20);
        check("after_to_result0", 32'(result0), 32'd16);

        // Reset while arvalid is held, then a fresh tie.
        f_en = 1'b1; f_aw = 6; f_rw = 0; f_to = 1'b0; f_resp = 2'b00;
        set_req(0, 3'd1, 3'd2);
        set_req(1, 3'd3, 3'd3);
        for (int i = 0; i < 5 && !(active && cyc >= g); i++)
            step();
        apply_reset();
        run_idle(40);
        check("rst_result0", 32'(result0), 32'd2);
        check("rst_result1", 32'(result1), 32'd9);

        // Randomized traffic.
        rand_slave  = 1'b1;
        arrive_prob = 30;
        keep_prob   = 40;
        repeat (600) step();
        arrive_prob = 0;
        keep_prob   = 0;
        run_idle(200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
